fetch_stage: RTL and testbench

- Instruction-fetch stage for the pipelined core; the upstream neighbour of execute, branch comparison and PC selection.
- Owns the PC register and issues word reads to instruction memory, with one request outstanding at most.
- Presents {pc, pc+4, instruction} to decode with a valid/ready handshake.
- Consumes the redirect produced by execute (branch_taken OR jump) and squashes wrong-path fetches.

---
 rtl/fetch_stage_pkg.sv | 18 +
 rtl/fetch_skid_buf.sv | 62 ++++++
 rtl/fetch_stage.sv | 242 ++++++++++++++++++++++++
 tb/tb_fetch_stage.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
// Contents: default datapath width, fetch FSM state type, NOP encoding and PC increment.
package fetch_stage_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    localparam int unsigned PC_INCR = 4;

    typedef enum logic [1:0] {
        StIdle,  // no request outstanding
        StWait,  // one request outstanding
        StHold   // response parked in the skid buffer
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, instr} holding register used when a memory response returns while the
// fetch output register is still occupied.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   flush_i                    drop the held entry (wins over everything else)
//   in_valid_i/in_ready_o      upstream handshake, in_pc_i/in_instr_i payload
//   out_valid_o/out_ready_i    downstream handshake, out_pc_o/out_instr_o payload
module fetch_skid_buf
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_pc_i,
    input  logic [DATA_WIDTH-1:0] in_instr_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_pc_o,
    output logic [DATA_WIDTH-1:0] out_instr_o
);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] pc_q, instr_q;
    logic                  push;

    // Single entry: accept only when empty, so push and pop never coincide.
    assign in_ready_o  = !valid_q;
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign out_valid_o = valid_q;
    assign out_pc_o    = pc_q;
    assign out_instr_o = instr_q;

    always_comb begin
        valid_d = valid_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (push) begin
            valid_d = 1'b1;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (push) begin
                pc_q    <= in_pc_i;
                instr_q <= in_instr_i;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to instruction memory (at most one
// outstanding), and presents {pc, pc+4, instr} to decode over a valid/ready handshake.
// Redirects from execute squash wrong-path fetches.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN -- a misaligned redirect target presents a
// NOP bundle flagged by if_misalign_o and halts fetch until the next redirect. When undefined
// the target is word-aligned and if_misalign_o is constant 0.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   imem_req_o, imem_addr_o           read request pulse and byte address
//   imem_rvalid_i, imem_rdata_i       read response
//   redirect_i, redirect_pc_i         execute redirect and its target
//   if_valid_o, id_ready_i            output handshake to decode
//   if_pc_o, if_pc_plus4_o, if_instr_o, if_misalign_o   output bundle
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  if_valid_o,
    input  logic                  id_ready_i,
    output logic [DATA_WIDTH-1:0] if_pc_o,
    output logic [DATA_WIDTH-1:0] if_pc_plus4_o,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic                  if_misalign_o
);

    localparam logic [DATA_WIDTH-1:0] Incr = DATA_WIDTH'(PC_INCR);

    fetch_state_e          state_q, state_d;
    // In StWait pc_q is the address of the outstanding request; otherwise the next to fetch.
    logic [DATA_WIDTH-1:0] pc_q, pc_d, pc_next;
    logic                  kill_q, kill_d;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_pc_q, out_pc_d;
    logic [DATA_WIDTH-1:0] out_pc4_q, out_pc4_d;
    logic [DATA_WIDTH-1:0] out_instr_q, out_instr_d;
    logic                  out_mis_q, out_mis_d;

    logic [DATA_WIDTH-1:0] redirect_target;
    logic                  redirect_trap;
    logic                  halt;

    logic                  out_free;
    logic                  rsp_ok;
    logic                  skid_in_valid, skid_in_ready;
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_pc, skid_instr;

    assign pc_next = pc_q + Incr;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halt_q;

    assign redirect_target = redirect_pc_i;
    assign redirect_trap   = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign halt            = halt_q;

    // Set by a trapping redirect, cleared by any later redirect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            halt_q <= 1'b0;
        end else if (redirect_i) begin
            halt_q <= redirect_trap;
        end
    end
`else
    assign redirect_target = redirect_pc_i & ~DATA_WIDTH'(3);
    assign redirect_trap   = 1'b0;
    assign halt            = 1'b0;
`endif

    // The output register can take new data when empty or being consumed this cycle.
    assign out_free = !out_valid_q || id_ready_i;
    // A response that is on the correct path and not squashed by a coincident redirect.
    assign rsp_ok   = (state_q == StWait) && imem_rvalid_i && !kill_q && !redirect_i;
    assign skid_in_valid = rsp_ok && !out_free && skid_in_ready;

    fetch_skid_buf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (redirect_i),
        .in_valid_i (skid_in_valid),
        .in_ready_o (skid_in_ready),
        .in_pc_i    (pc_q),
        .in_instr_i (imem_rdata_i),
        .out_valid_o(skid_valid),
        .out_ready_i(out_free),
        .out_pc_o   (skid_pc),
        .out_instr_o(skid_instr)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            kill_q  <= kill_d;
        end
    end

    // Next-state logic: FSM, PC and kill flag.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        kill_d  = kill_q;
        if (redirect_i) begin
            pc_d = redirect_target;
            if ((state_q == StWait) && !imem_rvalid_i) begin
                // Wrong-path response still in flight: wait for it and discard it.
                kill_d = 1'b1;
            end else begin
                state_d = StIdle;
                kill_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!halt) begin
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (imem_rvalid_i) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = StIdle;
                        end else begin
                            pc_d = pc_next;
                            if (!out_free) begin
                                state_d = StHold;
                            end
                        end
                    end
                end
                StHold: begin
                    if (out_free) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Output logic: memory request.
    always_comb begin
        imem_req_o  = 1'b0;
        imem_addr_o = '0;
        if (!rst_i && !redirect_i) begin
            unique case (state_q)
                StIdle: begin
                    if (!halt) begin
                        imem_req_o  = 1'b1;
                        imem_addr_o = pc_q;
                    end
                end
                StWait: begin
                    // Back-to-back: next request in the same cycle the response is accepted.
                    if (imem_rvalid_i && !kill_q && out_free) begin
                        imem_req_o  = 1'b1;
                        imem_addr_o = pc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register next state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_pc4_d   = out_pc4_q;
        out_instr_d = out_instr_q;
        out_mis_d   = out_mis_q;
        if (redirect_i) begin
            out_valid_d = redirect_trap;
            out_mis_d   = redirect_trap;
            if (redirect_trap) begin
                out_pc_d    = redirect_target;
                out_pc4_d   = redirect_target + Incr;
                out_instr_d = INSTR_NOP;
            end
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_d = 1'b1;
                out_pc_d    = skid_pc;
                out_pc4_d   = skid_pc + Incr;
                out_instr_d = skid_instr;
                out_mis_d   = 1'b0;
            end else if (rsp_ok) begin
                out_valid_d = 1'b1;
                out_pc_d    = pc_q;
                out_pc4_d   = pc_next;
                out_instr_d = imem_rdata_i;
                out_mis_d   = 1'b0;
            end else begin
                out_valid_d = 1'b0;
                out_mis_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_pc4_q   <= '0;
            out_instr_q <= '0;
            out_mis_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_pc4_q   <= out_pc4_d;
            out_instr_q <= out_instr_d;
            out_mis_q   <= out_mis_d;
        end
    end

    assign if_valid_o    = out_valid_q;
    assign if_pc_o       = out_pc_q;
    assign if_pc_plus4_o = out_pc4_q;
    assign if_instr_o    = out_instr_q;
    assign if_misalign_o = out_mis_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. A second instance with RESET_PC=FFFF_FFFC shares all inputs
// to check PC wrap-around. Inputs change 1 time unit after the rising edge, outputs are
// checked on the falling edge.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        if_valid,  if_valid2;
    logic [31:0] if_pc,     if_pc2;
    logic [31:0] if_pc4,    if_pc42;
    logic [31:0] if_instr,  if_instr2;
    logic        if_mis,    if_mis2;

    int n_assert = 0;
    int n_fail   = 0;
    int lat      = 1;

    fetch_stage #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req),
        .imem_addr_o  (imem_addr),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .if_valid_o   (if_valid),
        .id_ready_i   (id_ready),
        .if_pc_o      (if_pc),
        .if_pc_plus4_o(if_pc4),
        .if_instr_o   (if_instr),
        .if_misalign_o(if_mis)
    );

    fetch_stage #(
        .DATA_WIDTH(32),
        .RESET_PC  (32'hFFFF_FFFC)
    ) dut_wrap (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imem_req2),
        .imem_addr_o  (imem_addr2),
        .imem_rvalid_i(imem_rvalid),
        .imem_rdata_i (imem_rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .if_valid_o   (if_valid2),
        .id_ready_i   (id_ready),
        .if_pc_o      (if_pc2),
        .if_pc_plus4_o(if_pc42),
        .if_instr_o   (if_instr2),
        .if_misalign_o(if_mis2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0050_0093;
        return 32'hCAFE_0000 ^ a;
    endfunction

    // Memory model: a request seen in cycle n is answered in cycle n+lat.
    initial begin : mem_model
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = '0;
        cnt = 0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                    pend        = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else if (imem_req) begin
                pend  = 1'b1;
                paddr = imem_addr;
                cnt   = lat;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b1;

        // Reset
        next_cycle(); next_cycle(); settle();
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_pc4", if_pc4, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chk("rst_mis", 32'(if_mis), 32'd0);

        // c1: first request
        next_cycle(); rst = 1'b0; settle();
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        chk("c1_wrap_addr", imem_addr2, 32'hFFFF_FFFC);
        chk("c1_valid", 32'(if_valid), 32'd0);

        // c2: response 0, next request at 4 in the same cycle
        next_cycle(); settle();
        chk("c2_req", 32'(imem_req), 32'd1);
        chk("c2_addr", imem_addr, 32'h4);
        chk("c2_wrap_addr", imem_addr2, 32'h0);
        chk("c2_valid", 32'(if_valid), 32'd0);

        // c3: first instruction presented
        next_cycle(); settle();
        chk("c3_valid", 32'(if_valid), 32'd1);
        chk("c3_pc", if_pc, 32'h0);
        chk("c3_pc4", if_pc4, 32'h4);
        chk("c3_instr", if_instr, mem_word(32'h0));
        chk("c3_addr", imem_addr, 32'h8);
        chk("c3_wrap_pc", if_pc2, 32'hFFFF_FFFC);
        chk("c3_wrap_pc4", if_pc42, 32'h0);

        // c4..c6: decode stalls; response for 0x8 goes to the skid buffer
        for (int i = 0; i < 3; i++) begin
            next_cycle(); id_ready = 1'b0; settle();
            chk("stall_valid", 32'(if_valid), 32'd1);
            chk("stall_pc", if_pc, 32'h4);
            chk("stall_pc4", if_pc4, 32'h8);
            chk("stall_instr", if_instr, 32'h0050_0093);
            chk("stall_req", 32'(imem_req), 32'd0);
        end

        // c7: transfer; skid drains, still no request
        next_cycle(); id_ready = 1'b1; settle();
        chk("c7_pc", if_pc, 32'h4);
        chk("c7_req", 32'(imem_req), 32'd0);

        // c8: skid entry presented, fetch resumes at 0xC
        next_cycle(); settle();
        chk("c8_valid", 32'(if_valid), 32'd1);
        chk("c8_pc", if_pc, 32'h8);
        chk("c8_instr", if_instr, mem_word(32'h8));
        chk("c8_req", 32'(imem_req), 32'd1);
        chk("c8_addr", imem_addr, 32'hC);

        // c9: request 0x10 with 3-cycle latency
        next_cycle(); lat = 3; settle();
        chk("c9_addr", imem_addr, 32'h10);

        // c10: redirect to 0x100 while 0x10 outstanding
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h100; settle();
        chk("c10_pc", if_pc, 32'hC);
        chk("c10_req", 32'(imem_req), 32'd0);

        // c11, c12: killed response in flight, then returns and is dropped
        next_cycle(); redirect = 1'b0; settle();
        chk("c11_valid", 32'(if_valid), 32'd0);
        chk("c11_req", 32'(imem_req), 32'd0);
        next_cycle(); settle();
        chk("c12_rvalid_seen", 32'(imem_rvalid), 32'd1);
        chk("c12_valid", 32'(if_valid), 32'd0);
        chk("c12_req", 32'(imem_req), 32'd0);

        // c13: request to target
        next_cycle(); lat = 1; settle();
        chk("c13_req", 32'(imem_req), 32'd1);
        chk("c13_addr", imem_addr, 32'h100);
        chk("c13_valid", 32'(if_valid), 32'd0);

        next_cycle(); settle();
        chk("c14_valid", 32'(if_valid), 32'd0);
        chk("c14_addr", imem_addr, 32'h104);

        // c15: redirect to 0x200 coincident with response for 0x104
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h200; settle();
        chk("c15_valid", 32'(if_valid), 32'd1);
        chk("c15_pc", if_pc, 32'h100);
        chk("c15_instr", if_instr, mem_word(32'h100));
        chk("c15_req", 32'(imem_req), 32'd0);

        next_cycle(); redirect = 1'b0; settle();
        chk("c16_valid", 32'(if_valid), 32'd0);
        chk("c16_req", 32'(imem_req), 32'd1);
        chk("c16_addr", imem_addr, 32'h200);

        next_cycle(); settle();
        chk("c17_valid", 32'(if_valid), 32'd0);

        next_cycle(); settle();
        chk("c18_valid", 32'(if_valid), 32'd1);
        chk("c18_pc", if_pc, 32'h200);
        chk("c18_instr", if_instr, mem_word(32'h200));

        // c19: misaligned redirect to 0x102
        next_cycle(); redirect = 1'b1; redirect_pc = 32'h102; settle();
        chk("c19_req", 32'(imem_req), 32'd0);
        next_cycle(); redirect = 1'b0; settle();
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_valid", 32'(if_valid), 32'd1);
        chk("mis_flag", 32'(if_mis), 32'd1);
        chk("mis_pc", if_pc, 32'h102);
        chk("mis_instr", if_instr, 32'h0000_0013);
        chk("mis_req", 32'(imem_req), 32'd0);
        next_cycle(); settle();
        chk("halt_valid", 32'(if_valid), 32'd0);
        chk("halt_req", 32'(imem_req), 32'd0);
        next_cycle(); settle();
        chk("halt_req2", 32'(imem_req), 32'd0);
`else
        chk("align_req", 32'(imem_req), 32'd1);
        chk("align_addr", imem_addr, 32'h100);
        chk("align_valid", 32'(if_valid), 32'd0);
        next_cycle(); settle();
        chk("align_addr2", imem_addr, 32'h104);
        next_cycle(); settle();
        chk("align_pc", if_pc, 32'h100);
        chk("align_instr", if_instr, mem_word(32'h100));
        chk("align_mis", 32'(if_mis), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
